// File: rtl/serv_seq_pkg.sv
// Shared types and constants for the serv PC/control sequencer.
package serv_seq_pkg;

  typedef enum logic [2:0] {
    ST_RST      = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_RUN_INIT = 3'd3,
    ST_RUN      = 3'd4
  } state_t;

  localparam int CNT_W = 5;

  // Only 1-bit and 4-bit datapath slices exist in the serial core.
  function automatic bit w_is_legal(input int w);
    return (w == 1) || (w == 4);
  endfunction

endpackage

// File: rtl/serv_bit_cnt.sv
// Bit-position counter for one instruction pass: W-step advance with stall
// hold, last-slice detect and per-bit strobe decode.
module serv_bit_cnt
  import serv_seq_pkg::*;
#(
  parameter int W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             stall,
  output logic [CNT_W-1:0] cnt,
  output logic             done,
  output logic             cnt0,
  output logic             cnt1,
  output logic             cnt2,
  output logic             cnt12to31
);

  localparam logic [CNT_W-1:0] STEP = CNT_W'(W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(32 - W);

  logic advance;

  assign advance = run & ~stall;

  // Counter advances one slice per unstalled run cycle; the modulo-32 wrap
  // after the last slice leaves it at 0 ready for the next pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= cnt + STEP;
    end
  end

  assign done      = advance & (cnt == LAST);
  assign cnt12to31 = run & (cnt >= CNT_W'(12));

  // A 4-bit slice at cnt==0 holds bits 0..3, so the low strobes coincide.
  generate
    if (W == 1) begin : g_w1
      assign cnt0 = run & (cnt == CNT_W'(0));
      assign cnt1 = run & (cnt == CNT_W'(1));
      assign cnt2 = run & (cnt == CNT_W'(2));
    end else begin : g_w4
      assign cnt0 = run & (cnt == CNT_W'(0));
      assign cnt1 = cnt0;
      assign cnt2 = cnt0;
    end
  endgenerate

endmodule

// File: rtl/serv_pc_seq.sv
// PC/control sequencer: ctrl reset window, ibus fetch handshake, decode slot
// and the optional init pass ahead of the PC update pass.
module serv_pc_seq
  import serv_seq_pkg::*;
#(
  parameter int W                 = 1,
  parameter int RESET_FETCH_DELAY = 1
) (
  input  logic             clk,
  input  logic             i_rst_n,
  output logic             o_ibus_cyc,
  input  logic             i_ibus_ack,
  input  logic             i_two_stage,
  input  logic             i_stall,
  output logic             o_ctrl_rst,
  output logic             o_pc_en,
  output logic             o_init,
  output logic             o_cnt0,
  output logic             o_cnt1,
  output logic             o_cnt2,
  output logic             o_cnt12to31,
  output logic             o_cnt_done,
  output logic [CNT_W-1:0] o_cnt
);

  generate
    if (!w_is_legal(W)) begin : g_bad_w
      $error("serv_pc_seq: W must be 1 or 4");
    end
    if (RESET_FETCH_DELAY < 1 || RESET_FETCH_DELAY > 3) begin : g_bad_delay
      $error("serv_pc_seq: RESET_FETCH_DELAY must be 1..3");
    end
  endgenerate

  localparam logic [1:0] RST_LOAD = 2'(RESET_FETCH_DELAY - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] rst_cnt;
  logic       run;
  logic       cnt_done;

  // State register; reset lands in RST from any point of a fetch or pass.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_RST;
    end else begin
      state <= state_nxt;
    end
  end

  // Down-counter stretching the serv_ctrl reset window after release.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_cnt <= RST_LOAD;
    end else if (state == ST_RST && rst_cnt != 2'd0) begin
      rst_cnt <= rst_cnt - 2'd1;
    end
  end

  // Next-state logic; inputs are only looked at in the state that owns them.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:      if (rst_cnt == 2'd0) state_nxt = ST_FETCH;
      ST_FETCH:    if (i_ibus_ack)      state_nxt = ST_DECODE;
      ST_DECODE:   state_nxt = i_two_stage ? ST_RUN_INIT : ST_RUN;
      ST_RUN_INIT: if (cnt_done)        state_nxt = ST_RUN;
      ST_RUN:      if (cnt_done)        state_nxt = ST_FETCH;
      default:     state_nxt = ST_RST;
    endcase
  end

  assign run        = (state == ST_RUN_INIT) | (state == ST_RUN);
  assign o_ctrl_rst = (state == ST_RST);
  assign o_ibus_cyc = (state == ST_FETCH);
  assign o_init     = (state == ST_RUN_INIT);
  assign o_pc_en    = (state == ST_RUN) & ~i_stall;
  assign o_cnt_done = cnt_done;

  serv_bit_cnt #(
    .W (W)
  ) u_bit_cnt (
    .clk       (clk),
    .rst_n     (i_rst_n),
    .run       (run),
    .stall     (i_stall),
    .cnt       (o_cnt),
    .done      (cnt_done),
    .cnt0      (o_cnt0),
    .cnt1      (o_cnt1),
    .cnt2      (o_cnt2),
    .cnt12to31 (o_cnt12to31)
  );

endmodule

// File: tb/tb_serv_pc_seq.sv
// Directed bench for serv_pc_seq: W=1 (delay 1) and W=4 (delay 2) instances.
module tb_serv_pc_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // W=1 instance signals
  logic       rst1_n, ack1, ts1, stall1;
  logic       cyc1, crst1, pcen1, init1, c0_1, c1_1, c2_1, c12_1, done1;
  logic [4:0] cnt1;
  // W=4 instance signals
  logic       rst4_n, ack4, ts4, stall4;
  logic       cyc4, crst4, pcen4, init4, c0_4, c1_4, c2_4, c12_4, done4;
  logic [4:0] cnt4;

  int passes = 0;
  int total  = 0;

  serv_pc_seq #(.W(1), .RESET_FETCH_DELAY(1)) dut1 (
    .clk(clk), .i_rst_n(rst1_n), .o_ibus_cyc(cyc1), .i_ibus_ack(ack1),
    .i_two_stage(ts1), .i_stall(stall1), .o_ctrl_rst(crst1), .o_pc_en(pcen1),
    .o_init(init1), .o_cnt0(c0_1), .o_cnt1(c1_1), .o_cnt2(c2_1),
    .o_cnt12to31(c12_1), .o_cnt_done(done1), .o_cnt(cnt1)
  );

  serv_pc_seq #(.W(4), .RESET_FETCH_DELAY(2)) dut4 (
    .clk(clk), .i_rst_n(rst4_n), .o_ibus_cyc(cyc4), .i_ibus_ack(ack4),
    .i_two_stage(ts4), .i_stall(stall4), .o_ctrl_rst(crst4), .o_pc_en(pcen4),
    .o_init(init4), .o_cnt0(c0_4), .o_cnt1(c1_4), .o_cnt2(c2_4),
    .o_cnt12to31(c12_4), .o_cnt_done(done4), .o_cnt(cnt4)
  );

  logic [13:0] v1, v4;
  assign v1 = {crst1, cyc1, pcen1, init1, c0_1, c1_1, c2_1, c12_1, done1, cnt1};
  assign v4 = {crst4, cyc4, pcen4, init4, c0_4, c1_4, c2_4, c12_4, done4, cnt4};

  function automatic logic [13:0] ev(input logic crst, input logic cyc, input logic pcen,
                                     input logic init, input logic c0, input logic c1,
                                     input logic c2, input logic c12, input logic done,
                                     input logic [4:0] cnt);
    return {crst, cyc, pcen, init, c0, c1, c2, c12, done, cnt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // FETCH with ack on the n-th cycle, then the DECODE slot.
  task automatic fetch1(input int n, input logic ts, input logic noise);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      ack1 = (i == n);
      #1;
      chk($sformatf("fetch_c%0d", i), v1, ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 5'd0));
    end
    @(negedge clk);
    ack1 = noise;
    ts1  = ts;
    #1;
    chk("decode", v1, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0));
  endtask

  // One pass on the W=1 instance against a small counter model.
  task automatic pass1(input logic init, input int stall_at, input int stall_n,
                       input logic noise, output int cycles, output int dones);
    logic [4:0] ec;
    int         left;
    logic       st;
    logic       fin;
    ec = 5'd0; left = stall_n; fin = 1'b0; cycles = 0; dones = 0;
    while (!fin && cycles < 100) begin
      @(negedge clk);
      st     = (int'(ec) == stall_at) && (left > 0);
      stall1 = st;
      ack1   = noise & cycles[0];
      ts1    = noise & cycles[1];
      #1;
      chk($sformatf("pass_i%0d_c%0d", init, cycles), v1,
          ev(0, 0, !init && !st, init, ec == 0, ec == 1, ec == 2, ec >= 12,
             ec == 31 && !st, ec));
      if (done1) dones++;
      if (st) left--;
      else begin
        fin = (ec == 5'd31);
        ec++;
      end
      cycles++;
    end
    stall1 = 1'b0; ack1 = 1'b0; ts1 = 1'b0;
    chk("pass_end_reached", 32'(fin), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, d;
    rst1_n = 0; ack1 = 0; ts1 = 0; stall1 = 0;
    rst4_n = 0; ack4 = 0; ts4 = 0; stall4 = 0;
    #1;
    chk("reset_w1", v1, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0));
    chk("reset_w4", v4, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0));

    // W=1 single-stage pass, ack on third fetch cycle
    @(negedge clk);
    rst1_n = 1;
    #1;
    chk("rst_window", v1, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0));
    fetch1(3, 0, 0);
    pass1(0, -1, 0, 0, a, d);
    chk("single_len", a, 32);
    chk("single_dones", d, 1);

    // Two-stage: init pass then PC pass, zero-wait ack
    fetch1(1, 1, 0);
    pass1(1, -1, 0, 0, a, d);
    pass1(0, -1, 0, 0, b, d);
    chk("two_stage_total", a + b, 64);

    // Stall 5 cycles at cnt=7
    fetch1(2, 0, 0);
    pass1(0, 7, 5, 0, a, d);
    chk("stall_len", a, 37);
    chk("stall_dones", d, 1);

    // Ack pulse in DECODE, ack/two_stage noise during RUN
    fetch1(1, 0, 1);
    pass1(0, -1, 0, 1, a, d);
    chk("noise_len", a, 32);

    // Async reset mid-RUN at cnt=15
    fetch1(1, 0, 0);
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      #1;
    end
    chk("pre_reset", v1, ev(0, 0, 1, 0, 0, 0, 0, 1, 0, 5'd15));
    rst1_n = 0;
    #1;
    chk("async_reset", v1, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0));
    @(negedge clk);
    #1;
    chk("held_reset", v1, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0));
    rst1_n = 1;
    #1;
    chk("rerst_window", v1, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0));
    fetch1(1, 0, 0);
    pass1(0, -1, 0, 0, a, d);
    chk("post_reset_len", a, 32);

    // W=4 instance, RESET_FETCH_DELAY=2
    @(negedge clk);
    rst4_n = 1;
    #1;
    chk("w4_rst_c1", v4, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0));
    @(negedge clk);
    #1;
    chk("w4_rst_c2", v4, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0));
    @(negedge clk);
    ack4 = 1;
    #1;
    chk("w4_fetch", v4, ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 5'd0));
    @(negedge clk);
    ack4 = 0; ts4 = 0;
    #1;
    chk("w4_decode", v4, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("w4_run_c%0d", k), v4,
          ev(0, 0, 1, 0, k == 0, k == 0, k == 0, k >= 3, k == 7, 5'(4 * k)));
    end
    @(negedge clk);
    #1;
    chk("w4_next_fetch", v4, ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 5'd0));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/serv_pc_seq.md
Name: serv_pc_seq

Overview:
- Sequences the bit-serial PC/control datapath (`serv_ctrl`).
- Runs the instruction-bus fetch handshake and holds a one-cycle decode slot.
- Generates the per-bit counter strobes (`cnt0`/`cnt1`/`cnt2`/`cnt12to31`) and the PC shift enable for every instruction pass, including an optional init pass before the update pass.
- Sits between the ibus slave, the decoder and `serv_ctrl`; supplies `serv_ctrl`'s synchronous reset pulse.

Parameters:
- W, 1, datapath slice width in bits per cycle; legal values 1 or 4.
- RESET_FETCH_DELAY, 1, number of `o_ctrl_rst` cycles after reset release before the first fetch (1..3).

Ports:
- clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- o_ibus_cyc  output  1  fetch request; held until ack
- i_ibus_ack  input  1  fetch complete; instruction valid this cycle
- i_two_stage  input  1  from decoder, sampled in DECODE: instruction needs an init pass before the PC pass
- i_stall  input  1  freezes the bit counter (memory or RF not ready)
- o_ctrl_rst  output  1  synchronous reset to `serv_ctrl` (loads RESET_PC)
- o_pc_en  output  1  PC shift enable to `serv_ctrl`
- o_init  output  1  high during the init pass
- o_cnt0  output  1  current slice contains bit 0
- o_cnt1  output  1  current slice contains bit 1
- o_cnt2  output  1  current slice contains bit 2
- o_cnt12to31  output  1  current slice lies in bits 12..31
- o_cnt_done  output  1  final slice of a pass, not stalled
- o_cnt  output  5  current bit index of the slice LSB

Behaviour:
- Reset (async, i_rst_n=0):
  - State goes to RST; counter cnt=0.
  - All outputs are 0 except `o_ctrl_rst`=1.
  - Reset takes effect immediately, mid-fetch or mid-pass; no partial pass resumes.
- State machine: RST, FETCH, DECODE, RUN_INIT, RUN.
- RST:
  - `o_ctrl_rst`=1 for RESET_FETCH_DELAY cycles after reset release (internal down-counter), then go to FETCH.
- FETCH:
  - `o_ibus_cyc`=1.
  - On a cycle with `i_ibus_ack`=1, go to DECODE at the next edge; `o_ibus_cyc` drops that same edge.
  - Ack in the first FETCH cycle is legal (zero-wait slave).
- DECODE:
  - One cycle. Sample `i_two_stage`: 1 → RUN_INIT, 0 → RUN. cnt=0.
- RUN_INIT / RUN:
  - cnt advances by W each cycle in which `i_stall`=0; cnt is held when `i_stall`=1.
  - `o_init`=1 throughout RUN_INIT.
  - `o_pc_en` = (state==RUN) & !`i_stall`. It is 0 throughout RUN_INIT.
- Pass end:
  - The last slice is cnt==32-W with `i_stall`=0; this asserts `o_cnt_done` for one cycle.
  - At the next edge cnt wraps to 0.
  - From RUN_INIT, go to RUN. From RUN, go to FETCH.
- Pass length:
  - One unstalled pass = 32/W cycles (32 for W=1, 8 for W=4).
  - A stall on the last slice delays `o_cnt_done` and the transition.
- Strobes (combinational from cnt and state; 0 outside RUN_INIT/RUN):
  - W=1: `o_cnt0`=(cnt==0), `o_cnt1`=(cnt==1), `o_cnt2`=(cnt==2).
  - W=4: `o_cnt0`, `o_cnt1` and `o_cnt2` are all (cnt==0).
  - `o_cnt12to31`=(cnt>=12), valid for both W.
- Ignored inputs:
  - `i_ibus_ack` outside FETCH.
  - `i_two_stage` outside DECODE.
  - `i_stall` outside RUN_INIT/RUN.
- Width rule:
  - cnt is 5 bits; the increment is modulo 32.
  - For W=4, cnt[1:0] is always 0.
- Simultaneous events:
  - Stall and last slice together: the stall wins, and the pass end waits.
  - Reset overrides everything.

Decomposition:
- Shared package `serv_seq_pkg`:
  - state enum (RST, FETCH, DECODE, RUN_INIT, RUN)
  - CNT_W=5
  - legal-W check constant
- Natural sub-module `serv_bit_cnt`: the cnt register with stall hold, W-step increment, last-slice detect and strobe decode.
- The FSM and ibus handshake stay in `serv_pc_seq`.

Test Plan:
- W=1, release reset, ack on the 3rd FETCH cycle, i_two_stage=0:
  - `o_ctrl_rst` high 1 cycle after release, then `o_ibus_cyc`=1 for 3 cycles.
  - DECODE 1 cycle, then 32 cycles of `o_pc_en`=1.
  - `o_cnt0` in run cycle 0, `o_cnt2` in run cycle 2, `o_cnt12to31` in run cycles 12..31.
  - `o_cnt_done` in run cycle 31, then `o_ibus_cyc`=1.
- W=1, i_two_stage=1 in DECODE:
  - 32 cycles with `o_init`=1 and `o_pc_en`=0, `o_cnt_done` at cycle 31.
  - Then 32 cycles with `o_pc_en`=1 and `o_init`=0.
  - 64 run cycles total before the next fetch.
- W=1, `i_stall`=1 for 5 cycles while cnt=7:
  - `o_cnt` stays at 7 and `o_pc_en`=0 for those 5 cycles.
  - Pass takes 37 cycles; `o_cnt_done` pulses once.
- W=4, single-stage pass:
  - 8 run cycles.
  - `o_cnt0`/`o_cnt1`/`o_cnt2` all 1 only in run cycle 0.
  - `o_cnt12to31`=1 in run cycles 3..7.
  - `o_cnt` sequence 0,4,...,28; `o_cnt_done` in cycle 7.
- Assert `i_rst_n`=0 asynchronously mid-RUN at cnt=15:
  - `o_pc_en`, `o_cnt*`, `o_ibus_cyc` go to 0 before the next edge.
  - `o_ctrl_rst`=1; after release the sequence restarts from RST.
- Pulse `i_ibus_ack` during RUN and DECODE, and toggle `i_two_stage` during RUN:
  - No state change.
  - Pass length and `o_init` unaffected.
